pattern_streamer: RTL and testbench

- Parametrised constant-pattern source: streams a compile-time table of LEN words, each DW bits wide, onto a valid/ready output.
- Supports one-shot, N-repeat and endless-loop modes, with start/abort control and a done pulse.
- Used as a deterministic stimulus/ID source in basic-verify sims and as a boot/banner generator feeding downstream sinks that may stall.

---
 rtl/pattern_streamer.sv | 127 ++++++++++++
 tb/tb_pattern_streamer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_streamer.sv
// Constant-pattern source: streams a compile-time table of LEN words onto a
// valid/ready output in one-shot, N-repeat or endless-loop mode.
module pattern_streamer #(
    parameter int unsigned       DW      = 8,
    parameter int unsigned       LEN     = 25,
    parameter logic [DW*LEN-1:0] PATTERN = '0,
    parameter int unsigned       CNTW    = 8,
    parameter int unsigned       IW      = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            loop_en,
    input  logic [CNTW-1:0] repeat_n,
    input  logic            abort,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [DW-1:0]   o_data,
    output logic [IW-1:0]   o_idx,
    output logic            o_last,
    output logic            busy,
    output logic            done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

    state_t          state, state_n;
    logic [IW-1:0]   idx_q, idx_n;
    logic [DW-1:0]   data_q, data_n;
    logic [CNTW-1:0] passes_q, passes_n;
    logic            loop_q, loop_n;
    logic            done_q, done_n;
    logic            running;
    logic            hs;
    logic            at_last;

    // Element 0 lives in the MSBs so string literals stream first-character-first.
    function automatic logic [DW-1:0] elem(input logic [IW-1:0] k);
        logic [DW*LEN-1:0] shifted;
        int unsigned       kk;
        kk      = int'(k);
        shifted = PATTERN >> (DW * (LEN - 1 - kk));
        return shifted[DW-1:0];
    endfunction

    assign running = (state == RUN);
    assign at_last = (idx_q == LAST_IDX);
    assign hs      = running & o_ready;

    // State and datapath register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            passes_q <= '0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            idx_q    <= idx_n;
            data_q   <= data_n;
            passes_q <= passes_n;
            loop_q   <= loop_n;
            done_q   <= done_n;
        end
    end

    // Next-state logic; abort overrides both start and a pending handshake
    always_comb begin
        state_n  = state;
        idx_n    = idx_q;
        passes_n = passes_q;
        loop_n   = loop_q;
        done_n   = 1'b0;

        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n  = RUN;
                        idx_n    = '0;
                        loop_n   = loop_en;
                        passes_n = (repeat_n == '0) ? CNTW'(1) : repeat_n;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (!at_last) begin
                            idx_n = IW'(idx_q + 1'b1);
                        end else if (loop_q) begin
                            idx_n = '0;
                        end else if (passes_q > CNTW'(1)) begin
                            passes_n = passes_q - 1'b1;
                            idx_n    = '0;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Data only reloads while streaming; after a run it holds its last value
        data_n = (state_n == RUN) ? elem(idx_n) : data_q;
    end

    // Output logic
    always_comb begin
        o_valid = running;
        busy    = running;
        o_last  = running & at_last;
        o_data  = data_q;
        o_idx   = idx_q;
        done    = done_q;
    end

endmodule

// File: tb/tb_pattern_streamer.sv
// Randomized self-checking bench for pattern_streamer against a queue-based
// model of the expected beat sequence ("HELLO" table plus a 1-element table).
module tb_pattern_streamer;

    localparam int DW   = 8;
    localparam int LEN  = 5;
    localparam int CNTW = 8;
    localparam int IW   = 3;
    localparam logic [DW*LEN-1:0] PAT = "HELLO";

    string ref_s = "HELLO";
    int checks = 0;
    int passed = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            start, loop_en, abort, o_ready;
    logic [CNTW-1:0] repeat_n;
    logic            o_valid, o_last, busy, done;
    logic [DW-1:0]   o_data;
    logic [IW-1:0]   o_idx;

    logic            start1, loop1, abort1, ready1;
    logic [7:0]      rep1;
    logic            valid1, last1, busy1, done1;
    logic [7:0]      data1;
    logic [0:0]      idx1;

    pattern_streamer #(.DW(DW), .LEN(LEN), .PATTERN(PAT), .CNTW(CNTW), .IW(IW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .repeat_n(repeat_n),
        .abort(abort), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_idx(o_idx), .o_last(o_last), .busy(busy), .done(done)
    );

    pattern_streamer #(.DW(8), .LEN(1), .PATTERN(8'hA5), .CNTW(8), .IW(1)) u_one (
        .clk(clk), .rst(rst), .start(start1), .loop_en(loop1), .repeat_n(rep1),
        .abort(abort1), .o_valid(valid1), .o_ready(ready1), .o_data(data1),
        .o_idx(idx1), .o_last(last1), .busy(busy1), .done(done1)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    // Expected {valid,busy,done,data,idx,last} for an active beat at element k
    function automatic logic [14:0] beat_vec(input int k);
        return {1'b1, 1'b1, 1'b0, ref_s[k], 3'(k), 1'(k == LEN - 1)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        start = 0; loop_en = 0; repeat_n = '0; abort = 0; o_ready = 0;
        start1 = 0; loop1 = 0; rep1 = '0; abort1 = 0; ready1 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_valid, o_data, o_idx, o_last, busy, done} !== '0)
            $display("FAIL reset_main: got %h required 0", {o_valid, o_data, o_idx, o_last, busy, done});
        else passed++;
        checks++;
        if ({valid1, data1, idx1, last1, busy1, done1} !== '0)
            $display("FAIL reset_len1: got %h required 0", {valid1, data1, idx1, last1, busy1, done1});
        else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Finite run: model is the flat queue of element indices over all passes
    task automatic test_run_stream(input string name, input int rep, input int ready_pct,
                                   input bit chained, input bit chain_next, input int next_rep);
        int q[$];
        int npass;
        int cyc;
        logic [14:0] exp_v;
        npass = (rep == 0) ? 1 : rep;
        cyc = 0;
        for (int p = 0; p < npass; p++)
            for (int k = 0; k < LEN; k++) q.push_back(k);
        if (!chained) begin
            start = 1; loop_en = 0; repeat_n = CNTW'(rep);
        end
        @(negedge clk);
        start = 0;
        while (q.size() > 0 && cyc < 5000) begin
            exp_v = beat_vec(q[0]);
            checks++;
            if ({o_valid, busy, done, o_data, o_idx, o_last} !== exp_v)
                $display("FAIL %s beat (remaining %0d): got %h required %h", name, q.size(),
                         {o_valid, busy, done, o_data, o_idx, o_last}, exp_v);
            else passed++;
            o_ready  = ($urandom_range(99) < ready_pct);
            start    = 1'($urandom_range(1));
            loop_en  = 1'($urandom_range(1));
            repeat_n = CNTW'($urandom);
            if (o_ready) void'(q.pop_front());
            @(negedge clk);
            cyc++;
        end
        start = 0; loop_en = 0; o_ready = 1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL %s timeout: got %0d beats left required 0", name, q.size());
        end
        checks++;
        if ({o_valid, busy, done} !== 3'b001)
            $display("FAIL %s done_pulse: got %b required 001", name, {o_valid, busy, done});
        else passed++;
        if (chain_next) begin
            start = 1; loop_en = 0; repeat_n = CNTW'(next_rep);
        end else begin
            @(negedge clk);
            checks++;
            if ({o_valid, busy, done} !== 3'b000)
                $display("FAIL %s after_done: got %b required 000", name, {o_valid, busy, done});
            else passed++;
        end
    endtask

    task automatic test_loop_abort();
        start = 1; loop_en = 1; repeat_n = 8'd1; o_ready = 1;
        @(negedge clk);
        start = 0; loop_en = 0;
        for (int beat = 0; beat <= 12; beat++) begin
            checks++;
            if ({o_valid, busy, done, o_data, o_idx, o_last} !== beat_vec(beat % LEN))
                $display("FAIL loop beat %0d: got %h required %h", beat,
                         {o_valid, busy, done, o_data, o_idx, o_last}, beat_vec(beat % LEN));
            else passed++;
            start = (beat == 5);
            abort = (beat == 12);
            @(negedge clk);
        end
        start = 0; abort = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({o_valid, busy, done} !== 3'b000)
                $display("FAIL abort_idle %0d: got %b required 000", i, {o_valid, busy, done});
            else passed++;
            @(negedge clk);
        end
        abort = 1; start = 1;
        @(negedge clk);
        abort = 0; start = 0;
        checks++;
        if ({o_valid, busy, done} !== 3'b000)
            $display("FAIL abort_beats_start: got %b required 000", {o_valid, busy, done});
        else passed++;
        start = 1; repeat_n = '0;
        @(negedge clk);
        start = 0;
        checks++;
        if ({o_valid, busy, done, o_data, o_idx, o_last} !== beat_vec(0))
            $display("FAIL restart_after_abort: got %h required %h",
                     {o_valid, busy, done, o_data, o_idx, o_last}, beat_vec(0));
        else passed++;
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++;
        if ({o_valid, busy, done} !== 3'b000)
            $display("FAIL abort_second: got %b required 000", {o_valid, busy, done});
        else passed++;
    endtask

    task automatic test_len1();
        int beats;
        int cyc;
        start1 = 1; rep1 = '0; ready1 = 1;
        @(negedge clk);
        start1 = 0;
        checks++;
        if ({valid1, busy1, done1, data1, idx1, last1} !== {3'b110, 8'hA5, 1'b0, 1'b1})
            $display("FAIL len1_beat: got %h required %h",
                     {valid1, busy1, done1, data1, idx1, last1}, {3'b110, 8'hA5, 1'b0, 1'b1});
        else passed++;
        @(negedge clk);
        checks++;
        if ({valid1, busy1, done1} !== 3'b001)
            $display("FAIL len1_done: got %b required 001", {valid1, busy1, done1});
        else passed++;
        start1 = 1; rep1 = 8'd3;
        @(negedge clk);
        start1 = 0;
        beats = 0; cyc = 0;
        while (beats < 3 && cyc < 200) begin
            checks++;
            if ({valid1, busy1, done1, data1, idx1, last1} !== {3'b110, 8'hA5, 1'b0, 1'b1})
                $display("FAIL len1_rep beat %0d: got %h required %h", beats,
                         {valid1, busy1, done1, data1, idx1, last1}, {3'b110, 8'hA5, 1'b0, 1'b1});
            else passed++;
            ready1 = 1'($urandom_range(1));
            if (ready1) beats++;
            @(negedge clk);
            cyc++;
        end
        ready1 = 1;
        checks++;
        if ({valid1, busy1, done1} !== 3'b001)
            $display("FAIL len1_rep_done: got %b required 001", {valid1, busy1, done1});
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start = 1; loop_en = 0; repeat_n = 8'd2; o_ready = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_data, o_idx, o_last, busy, done} !== '0)
            $display("FAIL async_reset: got %h required 0", {o_valid, o_data, o_idx, o_last, busy, done});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_valid, busy, done} !== 3'b000)
            $display("FAIL after_reset_idle: got %b required 000", {o_valid, busy, done});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_run_stream("one_shot", 0, 100, 1'b0, 1'b0, 0);
        test_run_stream("backpressure", 0, 40, 1'b0, 1'b0, 0);
        test_run_stream("repeat3", 3, 100, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            test_run_stream("random", $urandom_range(4), $urandom_range(30, 100), 1'b0, 1'b0, 0);
        test_run_stream("b2b_first", 1, 100, 1'b0, 1'b1, 2);
        test_run_stream("b2b_second", 2, 70, 1'b1, 1'b0, 0);
        test_run_stream("max_repeat", 255, 100, 1'b0, 1'b0, 0);
        test_loop_abort();
        test_len1();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
